// File: rtl/rom_reader_pkg.sv
// Shared constants for the bipolar PROM scan reader: chip geometries,
// chip-select/operation codes and the reader FSM state type.
package rom_reader_pkg;

   // 556PT5 (IP3604 equivalent): 512 x 8
   localparam int IP3604_DATA_WIDTH    = 8;
   localparam int IP3604_ADDRESS_WIDTH = 9;

   // 556PT4 (IP3601 equivalent): 256 x 4
   localparam int IP3601_DATA_WIDTH    = 4;
   localparam int IP3601_ADDRESS_WIDTH = 8;

   // V1..V4 chip control codes, bit0 = V1
   localparam logic [3:0] OP_RESET = 4'b0000;
   localparam logic [3:0] OP_READ  = 4'b1100;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_CAPTURE,
      ST_PRESENT,
      ST_DONE
   } reader_state_t;

endpackage

// File: rtl/key_debouncer.sv
// Manual key conditioning: two-flop synchroniser, optional stability
// filter, and a single-cycle pulse on each accepted rising edge.
// Build option: define ROM_READER_DEBOUNCE_EN to require the synchronised
// level to hold for DEBOUNCE_CYCLES cycles before it is accepted;
// otherwise the synchronised level is used directly.
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic key_async,
   output logic key_press
);

   logic sync_meta;
   logic sync_level;
   logic level;
   logic level_q;

   // Bring the asynchronous key into the clk domain.
   // NOTE: sequential state always uses non-blocking assignments so every
   // flop samples the pre-edge value of its neighbours.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync_meta  <= 1'b0;
         sync_level <= 1'b0;
      end else begin
         sync_meta  <= key_async;
         sync_level <= sync_meta;
      end
   end

`ifdef ROM_READER_DEBOUNCE_EN
   localparam int COUNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic [COUNT_W-1:0] stable_count;

   // Accept a new level only after it has differed from the accepted one
   // for DEBOUNCE_CYCLES consecutive cycles; any bounce restarts the count.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         stable_count <= '0;
         level        <= 1'b0;
      end else if (sync_level == level) begin
         stable_count <= '0;
      end else if (stable_count == COUNT_W'(DEBOUNCE_CYCLES - 1)) begin
         stable_count <= '0;
         level        <= sync_level;
      end else begin
         stable_count <= stable_count + 1'b1;
      end
   end
`else
   localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;

   assign level = sync_level;
`endif

   // Remember the accepted level so only its rising edge produces a press.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign key_press = level & ~level_q;

endmodule

// File: rtl/rom_scan_reader.sv
// Bipolar PROM reader: manual single-step (increment/decrement keys) or a
// full-ROM automatic scan, presenting each captured word on a valid/ready
// stream. Build option: ROM_READER_DEBOUNCE_EN enables key debouncing
// inside key_debouncer.
module rom_scan_reader
   import rom_reader_pkg::*;
#(
   parameter int DATA_WIDTH      = IP3604_DATA_WIDTH,
   parameter int ADDRESS_WIDTH   = IP3604_ADDRESS_WIDTH,
   parameter int ACCESS_CYCLES   = 4,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     increment_key,
   input  logic                     decrement_key,
   input  logic                     auto_start,
   input  logic [DATA_WIDTH-1:0]    data_line_in,
   output logic [3:0]               operation,
   output logic [ADDRESS_WIDTH-1:0] address_line,
   output logic [DATA_WIDTH-1:0]    data_out,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic                     busy,
   output logic                     scan_done
);

   localparam int                     SETTLE_W     = $clog2(ACCESS_CYCLES + 1);
   localparam logic [ADDRESS_WIDTH-1:0] LAST_ADDRESS = '1;

   reader_state_t       state;
   logic                scan_mode;
   logic [SETTLE_W-1:0] settle_count;
   logic                inc_press;
   logic                dec_press;

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc_key (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_async (increment_key),
      .key_press (inc_press)
   );

   key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec_key (
      .clk       (clk),
      .reset_n   (reset_n),
      .key_async (decrement_key),
      .key_press (dec_press)
   );

   // Reader FSM with all outputs registered; requests outside IDLE are dropped.
   // NOTE: every register here is cleared by reset_n, including the data
   // path, so a mid-scan reset leaves no stale word on the stream.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state        <= ST_IDLE;
         address_line <= '0;
         data_out     <= '0;
         out_valid    <= 1'b0;
         busy         <= 1'b0;
         scan_done    <= 1'b0;
         operation    <= OP_RESET;
         scan_mode    <= 1'b0;
         settle_count <= '0;
      end else begin
         operation <= OP_READ;
         case (state)
            ST_IDLE: begin
               settle_count <= '0;
               if (auto_start) begin
                  address_line <= '0;
                  scan_mode    <= 1'b1;
                  busy         <= 1'b1;
                  state        <= ST_SETTLE;
               end else if (inc_press && !dec_press) begin
                  address_line <= address_line + ADDRESS_WIDTH'(1);
                  busy         <= 1'b1;
                  state        <= ST_SETTLE;
               end else if (dec_press && !inc_press) begin
                  address_line <= address_line - ADDRESS_WIDTH'(1);
                  busy         <= 1'b1;
                  state        <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (settle_count == SETTLE_W'(ACCESS_CYCLES - 1)) begin
                  settle_count <= '0;
                  state        <= ST_CAPTURE;
               end else begin
                  settle_count <= settle_count + 1'b1;
               end
            end
            ST_CAPTURE: begin
               data_out  <= data_line_in;
               out_valid <= 1'b1;
               state     <= ST_PRESENT;
            end
            ST_PRESENT: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (!scan_mode) begin
                     busy  <= 1'b0;
                     state <= ST_IDLE;
                  end else if (address_line == LAST_ADDRESS) begin
                     scan_done <= 1'b1;
                     state     <= ST_DONE;
                  end else begin
                     address_line <= address_line + ADDRESS_WIDTH'(1);
                     state        <= ST_SETTLE;
                  end
               end
            end
            ST_DONE: begin
               scan_done <= 1'b0;
               scan_mode <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
            default: begin
               out_valid <= 1'b0;
               scan_done <= 1'b0;
               scan_mode <= 1'b0;
               busy      <= 1'b0;
               state     <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rom_scan_reader.sv
// Self-checking bench for rom_scan_reader: 16 x 4 ROM whose contents are
// ~address, an expected-transfer queue model, and a per-cycle monitor.
module tb_rom_scan_reader;

   localparam int DW = 4;
   localparam int AW = 4;
   localparam int AC = 2;
   localparam int DC = 3;

   logic          clk           = 1'b0;
   logic          reset_n       = 1'b0;
   logic          increment_key = 1'b0;
   logic          decrement_key = 1'b0;
   logic          auto_start    = 1'b0;
   logic          out_ready     = 1'b0;
   logic [DW-1:0] data_line_in;
   logic [3:0]    operation;
   logic [AW-1:0] address_line;
   logic [DW-1:0] data_out;
   logic          out_valid;
   logic          busy;
   logic          scan_done;

   // ROM contents: each word is the bitwise inverse of its address
   assign data_line_in = ~address_line;

   rom_scan_reader #(
      .DATA_WIDTH      (DW),
      .ADDRESS_WIDTH   (AW),
      .ACCESS_CYCLES   (AC),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .increment_key (increment_key),
      .decrement_key (decrement_key),
      .auto_start    (auto_start),
      .data_line_in  (data_line_in),
      .operation     (operation),
      .address_line  (address_line),
      .data_out      (data_out),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .busy          (busy),
      .scan_done     (scan_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } xfer_t;

   xfer_t         exp_q[$];
   int            n_cmp      = 0;
   int            n_fail     = 0;
   int            n_xfer     = 0;
   int            n_done     = 0;
   logic [DW-1:0] last_data  = '0;
   logic [AW-1:0] model_addr = '0;
   bit            model_scan = 1'b0;
   bit            rand_ready = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void push(input logic [AW-1:0] a);
      xfer_t e;
      e.addr = a;
      e.data = ~a;
      exp_q.push_back(e);
   endfunction

   // ---------------- per-cycle monitor ----------------
   logic          rst_at_edge = 1'b0;
   logic          prev_valid  = 1'b0;
   logic          prev_ready  = 1'b0;
   logic          prev_xfer   = 1'b0;
   logic          prev_final  = 1'b0;
   logic [DW-1:0] prev_data   = '0;
   logic [AW-1:0] prev_addr   = '0;
   logic          cur_xfer;
   xfer_t         cmp_e;

   always @(posedge clk) rst_at_edge <= reset_n;

   always @(negedge clk) begin
      if (!rst_at_edge) begin
         check("rst_address", 32'(address_line), 32'h0);
         check("rst_data_out", 32'(data_out), 32'h0);
         check("rst_out_valid", 32'(out_valid), 32'h0);
         check("rst_busy", 32'(busy), 32'h0);
         check("rst_scan_done", 32'(scan_done), 32'h0);
         check("rst_operation", 32'(operation), 32'h0);
         prev_valid = 1'b0;
         prev_ready = 1'b0;
         prev_xfer  = 1'b0;
         prev_final = 1'b0;
      end else begin
         check("operation", 32'(operation), 32'hC);
         check("scan_done", 32'(scan_done), 32'(prev_final));
         if (scan_done) n_done++;
         if (prev_valid && !prev_ready) begin
            check("hold_valid", 32'(out_valid), 32'h1);
            check("hold_data", 32'(data_out), 32'(prev_data));
            check("hold_addr", 32'(address_line), 32'(prev_addr));
         end
         if (prev_xfer) check("valid_drop", 32'(out_valid), 32'h0);
         if (out_valid) begin
            check("rom_word", 32'(data_out), 32'(data_line_in));
            check("busy_with_valid", 32'(busy), 32'h1);
         end
         cur_xfer = out_valid && out_ready;
         if (cur_xfer) begin
            if (exp_q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_xfer: got addr %0h data %0h, expected no transfer", address_line, data_out);
            end else begin
               cmp_e = exp_q.pop_front();
               check("xfer_addr", 32'(address_line), 32'(cmp_e.addr));
               check("xfer_data", 32'(data_out), 32'(cmp_e.data));
            end
            n_xfer++;
            last_data = data_out;
         end
         prev_final = cur_xfer && model_scan && (address_line == 4'hF);
         prev_valid = out_valid;
         prev_ready = out_ready;
         prev_data  = data_out;
         prev_addr  = address_line;
         prev_xfer  = cur_xfer;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while (exp_q.size() != 0 || busy) begin
         if (n == budget) begin
            n_cmp++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d words outstanding, expected 0 within %0d cycles", exp_q.size(), budget);
            exp_q.delete();
            return;
         end
         tick();
         n++;
      end
   endtask

   task automatic press(input bit inc, input bit dec, input int hold);
      if (inc && !dec) begin
         model_addr = model_addr + 4'd1;
         push(model_addr);
      end else if (dec && !inc) begin
         model_addr = model_addr - 4'd1;
         push(model_addr);
      end
      increment_key = inc;
      decrement_key = dec;
      repeat (hold) tick();
      increment_key = 1'b0;
      decrement_key = 1'b0;
      repeat (8) tick();
      drain(200);
   endtask

   task automatic start_scan();
      model_scan = 1'b1;
      for (int i = 0; i < 16; i++) push(AW'(i));
      model_addr = 4'hF;
      auto_start = 1'b1;
      tick();
      auto_start = 1'b0;
   endtask

   // ---------------- test sequence ----------------
   int  xfer0;
   int  done0;
   int  op;
   int  hold;
   int  scans_left;
   bit  found;

   initial begin
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      #1;
      check("op_after_release", 32'(operation), 32'hC);

      // one increment: address 1, word E, single transfer
      xfer0 = n_xfer;
      press(1'b1, 1'b0, 6);
      check("inc_addr", 32'(address_line), 32'h1);
      check("inc_data", 32'(last_data), 32'hE);
      check("inc_count", 32'(n_xfer - xfer0), 32'd1);

      // back to 0, then decrement wraps to F with word 0
      press(1'b0, 1'b1, 6);
      press(1'b0, 1'b1, 12);
      check("dec_wrap_addr", 32'(address_line), 32'hF);
      check("dec_wrap_data", 32'(last_data), 32'h0);

      // increment wraps F -> 0
      press(1'b1, 1'b0, 12);
      check("inc_wrap_addr", 32'(address_line), 32'h0);
      check("inc_wrap_data", 32'(last_data), 32'hF);

      // both keys together cancel out
      increment_key = 1'b1;
      decrement_key = 1'b1;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("both_keys_busy", 32'(busy), 32'h0);
      end
      increment_key = 1'b0;
      decrement_key = 1'b0;
      repeat (10) tick();
      check("both_keys_addr", 32'(address_line), 32'h0);

`ifdef ROM_READER_DEBOUNCE_EN
      // two-cycle glitch shorter than the debounce window
      increment_key = 1'b1;
      repeat (2) tick();
      increment_key = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tick();
         check("glitch_busy", 32'(busy), 32'h0);
      end
      check("glitch_addr", 32'(address_line), 32'h0);
`endif

      // full scan with ready always high
      xfer0 = n_xfer;
      done0 = n_done;
      start_scan();
      drain(600);
      model_scan = 1'b0;
      check("scan_count", 32'(n_xfer - xfer0), 32'd16);
      check("scan_done_count", 32'(n_done - done0), 32'd1);
      check("scan_final_addr", 32'(address_line), 32'hF);
      check("scan_last_data", 32'(last_data), 32'h0);

      // scan stalled at address 5, then reset mid-scan
      model_addr = 4'h0;
      start_scan();
      found = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk);
         #1;
         if (out_valid && address_line == 4'h5) begin
            out_ready = 1'b0;
            found     = 1'b1;
         end else begin
            out_ready = 1'b1;
         end
      end
      check("stall_reached", 32'(found), 32'h1);
      for (int i = 0; i < 10; i++) begin
         @(posedge clk);
         #1;
         check("stall_data", 32'(data_out), 32'hA);
         check("stall_valid", 32'(out_valid), 32'h1);
      end
      out_ready = 1'b1;
      found     = 1'b0;
      for (int i = 0; i < 300 && !found; i++) begin
         @(posedge clk);
         #1;
         if (out_valid && address_line == 4'h8) found = 1'b1;
      end
      check("mid_scan_reached", 32'(found), 32'h1);
      out_ready  = 1'b0;
      reset_n    = 1'b0;
      model_scan = 1'b0;
      model_addr = 4'h0;
      exp_q.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("midrst_addr", 32'(address_line), 32'h0);
      check("midrst_valid", 32'(out_valid), 32'h0);
      check("midrst_busy", 32'(busy), 32'h0);
      check("midrst_op", 32'(operation), 32'h0);
      reset_n = 1'b1;
      repeat (4) tick();

      // randomized key presses and scans with random backpressure
      rand_ready = 1'b1;
      scans_left = 2;
      for (int i = 0; i < 30; i++) begin
         op   = $urandom_range(0, 9);
         hold = $urandom_range(6, 12);
         if (op == 0 && scans_left > 0) begin
            scans_left--;
            done0 = n_done;
            start_scan();
            drain(800);
            model_scan = 1'b0;
            check("rand_scan_done", 32'(n_done - done0), 32'd1);
         end else if (op < 6) begin
            press(1'b1, 1'b0, hold);
         end else begin
            press(1'b0, 1'b1, hold);
         end
         check("rand_addr", 32'(address_line), 32'(model_addr));
      end
      repeat (4) tick();
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got no completion, expected finish within 50000 cycles");
      $fatal(1);
   end

endmodule
